// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the multi-cycle ALU (alu_mc, alu_core).
// Contents: operation mode enum, FSM state enum, LAT_SINGLE latency constant.
package alu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_MUL = 3'd7
    } alu_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HOLD
    } alu_state_e;

    localparam int LAT_SINGLE = 1;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU ops (ADD, SUB, AND, OR, XOR).
// Ports: mode (operation), a/b (operands), c_in (carry/borrow in),
//        x (result), c_out (carry for ADD, borrow for SUB, 0 otherwise).
// Modes outside the single-cycle set return x=0, c_out=0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  alu_mode_e        mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] x,
    output logic             c_out
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        // a negative difference wraps so bit WIDTH reads as the borrow
        diff  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_in};
        x     = '0;
        c_out = 1'b0;
        case (mode)
            ALU_ADD: {c_out, x} = sum;
            ALU_SUB: {c_out, x} = diff;
            ALU_AND: x = a & b;
            ALU_OR:  x = a | b;
            ALU_XOR: x = a ^ b;
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on input and output.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + mode/a/b/c_in accept a bundle;
//        out_valid/out_ready + x/c_out/err return the result, held until taken.
// Logic ops take 1 cycle, shifts one bit per cycle, multiply one partial product per cycle.
// Macro ALU_MUL_EN: when defined mode 111 multiplies; otherwise it completes at once with err=1.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             c_out,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);
`ifdef ALU_MUL_EN
    // work register doubles as {accumulator, multiplier} during MUL
    localparam int WW = 2 * WIDTH;
`else
    localparam int WW = WIDTH;
`endif

    alu_state_e       state_q, state_d;
    alu_mode_e        mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, x_q, x_d;
    logic             cin_q, cin_d, cout_q, cout_d, err_q, err_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WW-1:0]    w_q, w_d;
    logic [WIDTH-1:0] core_x, shl, shr;
    logic             core_c, accept, is_shift;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .mode  (mode_q),
        .a     (a_q),
        .b     (b_q),
        .c_in  (cin_q),
        .x     (core_x),
        .c_out (core_c)
    );

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_HOLD && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_shift  = (mode == ALU_SHL) || (mode == ALU_SHR);
    assign shl       = {w_q[WIDTH-2:0], 1'b0};
    assign shr       = {1'b0, w_q[WIDTH-1:1]};
    assign out_valid = (state_q == ST_HOLD);
    assign x         = x_q;
    assign c_out     = cout_q;
    assign err       = err_q;

`ifdef ALU_MUL_EN
    logic [WIDTH:0] psum;
    logic [WW-1:0]  prod;
    // add the multiplicand if the multiplier LSB is set, then shift the pair right
    assign psum = {1'b0, w_q[WW-1:WIDTH]} + {1'b0, a_q & {WIDTH{w_q[0]}}};
    assign prod = {psum, w_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        x_d     = x_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            ST_EXEC: begin
                case (mode_q)
                    ALU_SHL, ALU_SHR: begin
                        if (cnt_q == '0) begin
                            x_d     = w_q[WIDTH-1:0];
                            cout_d  = 1'b0;
                            state_d = ST_HOLD;
                        end else begin
                            w_d[WIDTH-1:0] = (mode_q == ALU_SHL) ? shl : shr;
                            cnt_d          = cnt_q - 1'b1;
                            if (cnt_q == (SHW+1)'(1)) begin
                                x_d     = (mode_q == ALU_SHL) ? shl : shr;
                                cout_d  = (mode_q == ALU_SHL) ? w_q[WIDTH-1] : w_q[0];
                                state_d = ST_HOLD;
                            end
                        end
                    end
`ifdef ALU_MUL_EN
                    ALU_MUL: begin
                        w_d   = prod;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == (SHW+1)'(1)) begin
                            x_d     = prod[WIDTH-1:0];
                            cout_d  = |prod[WW-1:WIDTH];
                            state_d = ST_HOLD;
                        end
                    end
`endif
                    default: begin
                        x_d     = core_x;
                        cout_d  = core_c;
`ifdef ALU_MUL_EN
                        err_d   = 1'b0;
`else
                        err_d   = (mode_q == ALU_MUL);
`endif
                        state_d = ST_HOLD;
                    end
                endcase
            end
            ST_HOLD: state_d = out_ready ? ST_IDLE : ST_HOLD;
            default: ;
        endcase
        // a new bundle overrides the HOLD exit, so consume and capture share one edge
        if (accept) begin
            state_d        = ST_EXEC;
            mode_d         = alu_mode_e'(mode);
            a_d            = a;
            b_d            = b;
            cin_d          = c_in;
            err_d          = 1'b0;
            w_d            = '0;
            w_d[WIDTH-1:0] = is_shift ? a : b;
            cnt_d          = is_shift ? {1'b0, b[SHW-1:0]}
                           : (mode == ALU_MUL) ? (SHW+1)'(WIDTH) : (SHW+1)'(LAT_SINGLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= ALU_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            w_q     <= '0;
            x_q     <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            x_q     <= x_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=16) with a behavioural reference model.
module tb_alu_mc;
    localparam int W = 16;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, c_in = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, c_out, err;
    logic [W-1:0] x;
    int           checks = 0, passes = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .c_out     (c_out),
        .err       (err)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // expected result and latency straight from the operation definitions
    function automatic void model(input logic [2:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic ci, output logic [W-1:0] ex, output logic ec,
                                  output logic ee, output int lat);
        longint ua, ub, s;
        int n;
        ua = longint'(av);
        ub = longint'(bv);
        n = int'(bv % W);
        ex = '0;
        ec = 1'b0;
        ee = 1'b0;
        lat = 1;
        case (m)
            3'd0: begin s = ua + ub + longint'(ci); ex = W'(s); ec = s >= (longint'(1) << W); end
            3'd1: begin s = ua - ub - longint'(ci); ex = W'(s); ec = s < 0; end
            3'd2: ex = av & bv;
            3'd3: ex = av | bv;
            3'd4: ex = av ^ bv;
            3'd5: begin
                ex = W'(ua << n);
                ec = (n != 0) && (((ua >> (W - n)) & 1) != 0);
                lat = (n == 0) ? 1 : n;
            end
            3'd6: begin
                ex = W'(ua >> n);
                ec = (n != 0) && (((ua >> (n - 1)) & 1) != 0);
                lat = (n == 0) ? 1 : n;
            end
            default: begin
`ifdef ALU_MUL_EN
                s = ua * ub;
                ex = W'(s);
                ec = (s >> W) != 0;
                lat = W;
`else
                ee = 1'b1;
`endif
            end
        endcase
    endfunction

    // scoreboard: one outstanding bundle, counts down to its result, then waits to be taken
    logic         pend = 1'b0;
    int           wait_n = 0;
    logic [W-1:0] m_x;
    logic         m_c, m_e;
    logic         exp_ov, exp_rdy;

    initial forever begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            pend = 1'b0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
        end else begin
            exp_ov  = pend && wait_n == 0;
            exp_rdy = !pend || (exp_ov && out_ready);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, exp_rdy);
            if (exp_ov) begin
                chk("x", x, m_x);
                chk("c_out", c_out, m_c);
                chk("err", err, m_e);
            end
            if (pend && wait_n > 0) wait_n--;
            if (exp_ov && out_ready) pend = 1'b0;
            if (in_valid && exp_rdy) begin
                model(mode, a, b, c_in, m_x, m_c, m_e, wait_n);
                pend = 1'b1;
            end
        end
    end

    task automatic run_op(input logic [2:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic [W-1:0] xx, input logic cc, input logic ee,
                          input int ll, input string nm);
        int n;
        @(negedge clk);
        mode = m; a = av; b = bv; c_in = ci; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        chk({nm, "_x"}, x, xx);
        chk({nm, "_c"}, c_out, cc);
        chk({nm, "_err"}, err, ee);
        chk({nm, "_lat"}, n, ll);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] px;
        logic         pc, pe;
        int           pl;

        // pin the model against hand-computed values
        model(3'd5, 16'h8001, 16'h0003, 1'b0, px, pc, pe, pl);
        chk("model_shl_x", px, 16'h0008); chk("model_shl_c", pc, 0); chk("model_shl_lat", pl, 3);
        model(3'd1, 16'h0000, 16'h0001, 1'b0, px, pc, pe, pl);
        chk("model_sub_x", px, 16'hFFFF); chk("model_sub_c", pc, 1);
        model(3'd6, 16'h0005, 16'h0001, 1'b0, px, pc, pe, pl);
        chk("model_shr_x", px, 16'h0002); chk("model_shr_c", pc, 1);

        repeat (2) @(negedge clk);
        chk("reset_x", x, 0); chk("reset_c", c_out, 0); chk("reset_err", err, 0);
        chk("reset_out_valid", out_valid, 0); chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;

        run_op(3'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1, "add");
        run_op(3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1, "sub");
        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1, "add_wrap");
        run_op(3'd4, 16'hF0F0, 16'h0FF0, 1'b1, 16'hFF00, 1'b0, 1'b0, 1, "xor");
        run_op(3'd5, 16'h8001, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 3, "shl3");
        run_op(3'd6, 16'h0005, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 1, "shr1");
        run_op(3'd5, 16'h1234, 16'h0010, 1'b0, 16'h1234, 1'b0, 1'b0, 1, "shl0");
`ifdef ALU_MUL_EN
        run_op(3'd7, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 16, "mul_ovf");
        run_op(3'd7, 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0, 16, "mul");
`else
        run_op(3'd7, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1, 1, "mul_off");
`endif

        // backpressure: result must hold while a second bundle waits
        @(negedge clk);
        mode = 3'd0; a = 16'h0001; b = 16'h0002; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        a = 16'h0007; b = 16'h0009;
        @(negedge clk);
        repeat (5) begin
            chk("bp_x", x, 16'h0003); chk("bp_in_ready", in_ready, 0); chk("bp_out_valid", out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_busy", out_valid, 0);
        @(negedge clk);
        chk("bp_second_valid", out_valid, 1); chk("bp_second_x", x, 16'h0010);
        @(negedge clk);
        out_ready = 1'b0;

        // reset in the middle of a multiply
        @(negedge clk);
        mode = 3'd7; a = 16'h0100; b = 16'h0100; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0); chk("midrst_in_ready", in_ready, 1);
        chk("midrst_x", x, 0); chk("midrst_c", c_out, 0); chk("midrst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1, "post_rst_add");

        // randomized traffic, checked cycle by cycle against the scoreboard
        repeat (600) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            mode      = 3'($urandom);
            a         = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
            c_in      = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (24) @(negedge clk);
        chk("drain_idle", out_valid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
